cva6_lsu_mem_arbiter: RTL
=========================

# cva6_lsu_mem_arbiter

Sequences the LSU's single memory port between the load path and a small in-order store buffer. Stores enter the buffer speculatively, become drainable only after commit, and are dropped on flush if still uncommitted. Loads normally win the port, but a starvation counter and a load/store address-conflict check keep stores progressing and memory ordering correct. The block sits between the LSU load/store units and the data-cache request port, with one outstanding memory transaction at a time.

## Interface
- ADDR_W, 32, address width
- STORE_DEPTH, 4, store buffer entries (power of two, ≥2)
- STARVE_MAX, 4, consecutive load grants allowed while a committed store waits
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- ld_req_i  in  1  load request; held with ld_addr_i until ld_gnt_o
- ld_addr_i  in  ADDR_W  load address
- ld_gnt_o  out  1  one-cycle pulse: load accepted, address captured
- ld_rvalid_o  out  1  one-cycle pulse: load data returned
- st_valid_i  in  1  speculative store enqueue
- st_addr_i  in  ADDR_W  store address
- st_ready_o  out  1  buffer can accept a store this cycle
- st_commit_i  in  1  commit oldest uncommitted store
- flush_i  in  1  discard all uncommitted stores
- st_empty_o  out  1  store buffer holds no entries
- mem_req_o  out  1  memory request, held until mem_gnt_i
- mem_addr_o  out  ADDR_W  memory address (registered)
- mem_we_o  out  1  1 = store, 0 = load
- mem_gnt_i  in  1  memory accepted the request
- mem_rvalid_i  in  1  response (load data or store ack)

## Operation
- Buffer: circular, head/commit/tail pointers plus count.
- Enqueue when st_valid_i && st_ready_o. st_ready_o = !full && !flush_i, with full taken from registered count. A pop in the same cycle does not free a slot for that cycle's push.
- st_commit_i advances the commit pointer by one. It is ignored when no uncommitted entry exists.
- flush_i sets tail to the commit pointer. A commit in the same cycle applies first, so that entry survives the flush. Committed entries are never dropped.
- Conflict: a load conflicts if ld_addr_i[ADDR_W-1:2] equals the address of any valid buffer entry, committed or not. A conflicting load is not granted until no valid entry matches.
- FSM states and transitions:
  - IDLE → LD_REQ when a load is eligible and wins arbitration. ld_gnt_o pulses, address captured.
  - IDLE → ST_REQ when a committed head exists and wins arbitration.
  - LD_REQ → LD_RSP on mem_gnt_i.
  - LD_RSP → IDLE on mem_rvalid_i. ld_rvalid_o pulses.
  - ST_REQ → ST_RSP on mem_gnt_i.
  - ST_RSP → IDLE on mem_rvalid_i. Head entry popped.
- Arbitration in IDLE: the store wins if a committed head exists and (starve == STARVE_MAX, or the load is absent or conflicting). Otherwise the load wins.
- Starve counter, width $clog2(STARVE_MAX+1):
  - +1 on each load grant while a committed store is pending, saturating at STARVE_MAX.
  - Cleared on each store grant, and when no committed store is pending.
- mem_rvalid_i in IDLE, LD_REQ or ST_REQ is ignored.

## Timing
- Reset values: ld_gnt_o=0, ld_rvalid_o=0, st_ready_o=1, st_empty_o=1, mem_req_o=0, mem_we_o=0, mem_addr_o=0. FSM=IDLE, pointers, count and starve counter all 0.
- Reset asserted mid-transaction clears all state immediately. Any in-flight response is then ignored because the FSM is in IDLE.
- Arbitration is combinational in IDLE at cycle t. mem_req_o, mem_addr_o and mem_we_o are registered high from t+1.
- ld_gnt_o is combinational in cycle t.
- Minimum load latency is 3 cycles (grant t, gnt_i t+1, rvalid t+2, ld_rvalid_o t+2). The next arbitration is at t+3.
- mem_req_o drops the cycle after mem_gnt_i is sampled.
- st_empty_o is derived from registered count.
- A stored entry becomes drainable the cycle after its st_commit_i.

## Structure
- Package cva6_lsu_arb_pkg holds:
  - FSM state enum (IDLE, LD_REQ, LD_RSP, ST_REQ, ST_RSP).
  - Store entry struct {valid, committed, addr}.
- Sub-module cva6_lsu_store_queue holds the buffer, pointers, commit/flush logic and conflict compare. The arbiter FSM and starve counter stay in the top module.

## Test plan
- **Load only, empty buffer:** ld_req_i, addr 0x100, gnt_i 1 cycle later, rvalid next cycle → mem_we_o=0, mem_addr_o=0x100, ld_rvalid_o after 3 cycles, st_empty_o stays 1.
- **Store commit then drain:** enqueue 0x200, commit 2 cycles later → store request issued the cycle after commit; st_empty_o=1 after ack.
- **Flush:** enqueue 0x10, 0x14, 0x18; commit once; flush_i → only 0x10 drains; count 0 afterwards.
- **Conflict:** uncommitted store 0x40, then load 0x40 → no ld_gnt_o until commit + drain; load 0x44 in the same setup is granted immediately.
- **Starvation:** STARVE_MAX=4, committed store pending, ld_req_i held continuously → 4 load grants, then a store grant, then the counter is back at 0.
- **Full and reset:** 4 enqueues → st_ready_o=0; rst_i pulsed during LD_RSP → mem_req_o=0, st_empty_o=1, and a late mem_rvalid_i produces no ld_rvalid_o.

Source files
------------

// File: rtl/cva6_lsu_arb_pkg.sv
// Shared types for the LSU memory-port arbiter.
//   arb_state_e : arbiter FSM states
//   st_entry_t  : one store-buffer slot {valid, committed, addr}
package cva6_lsu_arb_pkg;

  // Entry address field is sized for the widest supported ADDR_W; narrower
  // configurations zero-extend into it and the unused upper bits are pruned.
  localparam int unsigned MaxAddrW = 64;

  typedef enum logic [2:0] {
    StIdle,
    StLdReq,
    StLdRsp,
    StStReq,
    StStRsp
  } arb_state_e;

  typedef struct packed {
    logic                valid;
    logic                committed;
    logic [MaxAddrW-1:0] addr;
  } st_entry_t;

endpackage

// File: rtl/cva6_lsu_store_queue.sv
// In-order speculative store buffer with commit/flush and load-address conflict check.
//   push/push_addr : enqueue a speculative store (accepted when ready)
//   commit         : mark the oldest uncommitted entry committed
//   flush          : drop every uncommitted entry (commit of the same cycle survives)
//   pop            : retire the committed head entry
//   ld_addr        : load address compared word-wise against all valid entries
//   ready/empty    : enqueue allowed / buffer holds nothing (registered count)
//   conflict       : load word address matches a valid entry
//   head_committed/head_addr : drainable head entry and its address
module cva6_lsu_store_queue
  import cva6_lsu_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic              commit,
  input  logic              flush,
  input  logic              pop,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ready,
  output logic              empty,
  output logic              conflict,
  output logic              head_committed,
  output logic [ADDR_W-1:0] head_addr
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  st_entry_t       ent_q [DEPTH];
  st_entry_t       ent_d [DEPTH];
  logic [PtrW-1:0] head_q, head_d, cptr_q, cptr_d, tail_q, tail_d;
  logic [CntW-1:0] cnt_q, cnt_d, ucnt_q, ucnt_d, ucnt_left;
  logic            full, do_push, do_commit, do_pop;
  logic            unused_addr_bits;

  assign full      = (cnt_q == CntW'(DEPTH));
  assign ready     = !full && !flush;
  assign empty     = (cnt_q == '0);
  assign do_push   = push && ready;
  assign do_commit = commit && (ucnt_q != '0);
  assign do_pop    = pop && head_committed;

  assign head_committed = ent_q[head_q].valid && ent_q[head_q].committed;
  assign head_addr      = ent_q[head_q].addr[ADDR_W-1:0];

  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_q[i].valid && (ent_q[i].addr[ADDR_W-1:2] == ld_addr[ADDR_W-1:2])) begin
        conflict = 1'b1;
      end
    end
  end

  // Upper entry bits beyond ADDR_W and the byte offset of the load address are never compared.
  always_comb begin
    unused_addr_bits = ^ld_addr[1:0];
    for (int i = 0; i < DEPTH; i++) begin
      unused_addr_bits = unused_addr_bits ^ (^ent_q[i].addr);
    end
  end

  always_comb begin
    ent_d  = ent_q;
    head_d = head_q;
    cptr_d = cptr_q;
    tail_d = tail_q;

    if (do_pop) begin
      ent_d[head_q].valid     = 1'b0;
      ent_d[head_q].committed = 1'b0;
      head_d                  = head_q + PtrW'(1);
    end
    if (do_push) begin
      ent_d[tail_q].valid     = 1'b1;
      ent_d[tail_q].committed = 1'b0;
      ent_d[tail_q].addr      = MaxAddrW'(push_addr);
      tail_d                  = tail_q + PtrW'(1);
    end
    if (do_commit) begin
      ent_d[cptr_q].committed = 1'b1;
      cptr_d                  = cptr_q + PtrW'(1);
    end

    ucnt_left = ucnt_q - CntW'(do_commit);

    // Flush never coincides with a push (ready is low), so only the commit needs ordering.
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_d[i].valid && !ent_d[i].committed) begin
          ent_d[i].valid = 1'b0;
        end
      end
      tail_d = cptr_d;
      ucnt_d = '0;
      cnt_d  = cnt_q - CntW'(do_pop) - ucnt_left;
    end else begin
      ucnt_d = ucnt_left + CntW'(do_push);
      cnt_d  = cnt_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      head_q <= '0;
      cptr_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      ucnt_q <= '0;
    end else begin
      ent_q  <= ent_d;
      head_q <= head_d;
      cptr_q <= cptr_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      ucnt_q <= ucnt_d;
    end
  end

endmodule

// File: rtl/cva6_lsu_mem_arbiter.sv
// Arbitrates the single LSU memory port between loads and the committed store buffer.
//   ld_req_i/ld_addr_i/ld_gnt_o/ld_rvalid_o : load path handshake
//   st_valid_i/st_addr_i/st_ready_o        : speculative store enqueue
//   st_commit_i/flush_i/st_empty_o         : commit, flush, buffer-empty status
//   mem_req_o/mem_addr_o/mem_we_o          : registered memory request
//   mem_gnt_i/mem_rvalid_i                 : memory accept and response
module cva6_lsu_mem_arbiter
  import cva6_lsu_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned STORE_DEPTH = 4,
  parameter int unsigned STARVE_MAX  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ld_req_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  output logic              ld_gnt_o,
  output logic              ld_rvalid_o,
  input  logic              st_valid_i,
  input  logic [ADDR_W-1:0] st_addr_i,
  output logic              st_ready_o,
  input  logic              st_commit_i,
  input  logic              flush_i,
  output logic              st_empty_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i
);

  localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);

  arb_state_e         state_q;
  logic               mem_req_q, mem_we_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [StarveW-1:0] starve_q;

  logic              conflict, head_committed, pop;
  logic [ADDR_W-1:0] head_addr;
  logic              idle, ld_ok, starve_hit, st_win, ld_win;

  cva6_lsu_store_queue #(
    .ADDR_W (ADDR_W),
    .DEPTH  (STORE_DEPTH)
  ) u_store_queue (
    .clk            (clk_i),
    .rst            (rst_i),
    .push           (st_valid_i),
    .push_addr      (st_addr_i),
    .commit         (st_commit_i),
    .flush          (flush_i),
    .pop            (pop),
    .ld_addr        (ld_addr_i),
    .ready          (st_ready_o),
    .empty          (st_empty_o),
    .conflict       (conflict),
    .head_committed (head_committed),
    .head_addr      (head_addr)
  );

  assign idle       = (state_q == StIdle);
  assign ld_ok      = ld_req_i && !conflict;
  assign starve_hit = (starve_q == StarveW'(STARVE_MAX));
  // A committed store takes the port when loads have starved it or cannot go anyway.
  assign st_win     = idle && head_committed && (starve_hit || !ld_ok);
  assign ld_win     = idle && ld_ok && !st_win;

  assign ld_gnt_o    = ld_win;
  assign ld_rvalid_o = (state_q == StLdRsp) && mem_rvalid_i;
  assign pop         = (state_q == StStRsp) && mem_rvalid_i;

  assign mem_req_o  = mem_req_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_we_o   = mem_we_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      starve_q   <= '0;
    end else begin
      if (st_win || !head_committed) begin
        starve_q <= '0;
      end else if (ld_win && !starve_hit) begin
        starve_q <= starve_q + StarveW'(1);
      end

      unique case (state_q)
        StIdle: begin
          if (st_win) begin
            state_q    <= StStReq;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b1;
            mem_addr_q <= head_addr;
          end else if (ld_win) begin
            state_q    <= StLdReq;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= ld_addr_i;
          end
        end
        StLdReq: begin
          if (mem_gnt_i) begin
            state_q   <= StLdRsp;
            mem_req_q <= 1'b0;
          end
        end
        StLdRsp: begin
          if (mem_rvalid_i) state_q <= StIdle;
        end
        StStReq: begin
          if (mem_gnt_i) begin
            state_q   <= StStRsp;
            mem_req_q <= 1'b0;
          end
        end
        StStRsp: begin
          if (mem_rvalid_i) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
